// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation codes, FSM states and opcode predicates.
package mdu_pkg;

  localparam int OP_W  = 4;
  localparam int CNT_W = 8;

  localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MD_MFHI  = 4'd5;
  localparam logic [OP_W-1:0] MD_MFLO  = 4'd6;
  localparam logic [OP_W-1:0] MD_MTHI  = 4'd7;
  localparam logic [OP_W-1:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  // Any MD-class instruction; the hazard unit stalls these in D while busy.
  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

  // Operations that launch a multi-cycle computation.
  function automatic logic is_start_op(input logic [OP_W-1:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core: full multiply / divide results for one op.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [OP_W-1:0] op,
  output logic [31:0]     hi_tmp,
  output logic [31:0]     lo_tmp,
  output logic            div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] safe_mag_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;

  assign prod_s = $signed({{32{in_a[31]}}, in_a}) * $signed({{32{in_b[31]}}, in_b});
  assign prod_u = {32'd0, in_a} * {32'd0, in_b};

  // Signed division works on magnitudes so INT_MIN / -1 wraps to INT_MIN
  // instead of hitting an undefined overflow; a zero divisor is replaced
  // by 1 to keep the datapath X-free (the result is discarded anyway).
  assign mag_a      = in_a[31] ? (32'd0 - in_a) : in_a;
  assign mag_b      = in_b[31] ? (32'd0 - in_b) : in_b;
  assign safe_b     = (in_b == 32'd0) ? 32'd1 : in_b;
  assign safe_mag_b = (in_b == 32'd0) ? 32'd1 : mag_b;
  assign uq         = in_a / safe_b;
  assign ur         = in_a % safe_b;
  assign sq_mag     = mag_a / safe_mag_b;
  assign sr_mag     = mag_a % safe_mag_b;

  // Select result for the requested operation.
  always_comb begin
    hi_tmp      = 32'd0;
    lo_tmp      = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT: begin
        hi_tmp = prod_s[63:32];
        lo_tmp = prod_s[31:0];
      end
      MD_MULTU: begin
        hi_tmp = prod_u[63:32];
        lo_tmp = prod_u[31:0];
      end
      MD_DIV: begin
        lo_tmp      = (in_a[31] ^ in_b[31]) ? (32'd0 - sq_mag) : sq_mag;
        hi_tmp      = in_a[31] ? (32'd0 - sr_mag) : sr_mag;
        div_by_zero = (in_b == 32'd0);
      end
      MD_DIVU: begin
        lo_tmp      = uq;
        hi_tmp      = ur;
        div_by_zero = (in_b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency mult/div with architectural HI/LO.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [OP_W-1:0] MDUOp,
  input  logic            valid,
  output logic            busy,
  output logic [31:0]     hi,
  output logic [31:0]     lo,
  output logic [31:0]     result
);

  mdu_state_t       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      hi_tmp_reg, hi_tmp_next;
  logic [31:0]      lo_tmp_reg, lo_tmp_next;
  logic             dz_reg, dz_next;

  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_dz;
  logic             idle_valid;

  mdu_calc u_calc (
    .in_a        (in_a),
    .in_b        (in_b),
    .op          (MDUOp),
    .hi_tmp      (calc_hi),
    .lo_tmp      (calc_lo),
    .div_by_zero (calc_dz)
  );

  assign idle_valid = valid && (state_reg == ST_IDLE);

  // Next-state logic: launch, count down, commit HI/LO or serve moves.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    hi_tmp_next = hi_tmp_reg;
    lo_tmp_next = lo_tmp_reg;
    dz_next     = dz_reg;
    case (state_reg)
      ST_IDLE: begin
        if (idle_valid && is_start_op(MDUOp)) begin
          state_next  = ST_RUN;
          count_next  = is_mult_op(MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          hi_tmp_next = calc_hi;
          lo_tmp_next = calc_lo;
          dz_next     = calc_dz;
        end else if (idle_valid && (MDUOp == MD_MTHI)) begin
          hi_next = in_a;
        end else if (idle_valid && (MDUOp == MD_MTLO)) begin
          lo_next = in_a;
        end
      end
      ST_RUN: begin
        count_next = count_reg - CNT_W'(1);
        // Final busy cycle: commit unless the divisor was zero.
        if (count_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          if (!dz_reg) begin
            hi_next = hi_tmp_reg;
            lo_next = lo_tmp_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      hi_tmp_reg <= 32'd0;
      lo_tmp_reg <= 32'd0;
      dz_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      hi_tmp_reg <= hi_tmp_next;
      lo_tmp_reg <= lo_tmp_next;
      dz_reg     <= dz_next;
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  // Register read for mfhi/mflo.
  always_comb begin
    result = 32'd0;
    if (MDUOp == MD_MFHI) result = hi_reg;
    else if (MDUOp == MD_MFLO) result = lo_reg;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit for the pipelined CPU's EX stage; sits beside the ALU and receives the same forwarded operands.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and holds the architectural HI/LO registers.
- Serves mfhi/mflo/mthi/mtlo.
- Drives `busy` so the hazard unit can stall MD-class instructions in D.

Parameters:
MULT_CYCLES, 5, cycles busy stays high for mult/multu
DIV_CYCLES, 10, cycles busy stays high for div/divu

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_a  input  32  rs operand (forwarded)
in_b  input  32  rt operand (forwarded)
MDUOp  input  4  operation code (package constants)
valid  input  1  EX holds a real instruction (low for bubbles)
busy  output  1  multi-cycle operation in flight
hi  output  32  architectural HI
lo  output  32  architectural LO
result  output  32  mfhi→hi, mflo→lo, otherwise 0 (combinational)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are `clk` and `reset`.
- Reset: busy=0, hi=0, lo=0, counter=0, pending results cleared.
- Reset mid-operation aborts it. No later HI/LO update occurs.
- Start condition at a rising edge: valid && !busy && MDUOp ∈ {MULT, MULTU, DIV, DIVU}.
- On a start edge:
  - Compute the full result into internal hi_tmp/lo_tmp.
  - Load counter = MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- States: IDLE and RUN.
- RUN behaviour:
  - Counter decrements each edge.
  - On the edge where counter reaches 0: hi<=hi_tmp, lo<=lo_tmp, busy<=0, return to IDLE.
  - busy is high for exactly N cycles. New HI/LO is visible in the first cycle busy is low.
- Back-to-back: a start presented in the first cycle busy is low is accepted.
- Start is never sampled while busy. Any MD op with valid && busy is ignored and must not change state. The hazard unit guarantees this by stalling.
- MTHI/MTLO:
  - Condition: valid && !busy.
  - Effect: hi<=in_a (or lo<=in_a) at the edge.
  - Other register unchanged.
  - Ignored while busy.
- MFHI/MFLO: purely combinational read of the current hi/lo. No state change.
- MULT: signed 32x32→64. HI=upper 32 bits, LO=lower 32 bits. MULTU: unsigned.
- DIV (signed):
  - LO=quotient truncated toward zero; HI=remainder with sign of dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (in_b==0): the operation still runs DIV_CYCLES with busy high, but HI/LO are left unchanged at completion.
- MD_NONE or unknown codes: no effect.
- valid=0: no effect regardless of MDUOp.

Decomposition:
- Shared package/header holds the MDUOp constants:
  - MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4
  - MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8
- The same package holds the predicate "is MD instruction" used by the hazard unit.
- One natural sub-module: `mdu_calc`. It is combinational and maps in_a, in_b, op to hi_tmp, lo_tmp and div_by_zero, keeping arithmetic separate from the counter/FSM.

Test Plan:
- MULT with in_a=0xFFFFFFFF, in_b=2, valid for one cycle:
  - busy high exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - Repeating as MULTU gives hi=0x00000001, lo=0xFFFFFFFE.
- DIV with in_a=-7, in_b=2:
  - busy high 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2 gives lo=3, hi=1.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- MTHI 0x1234, then MTLO 0x5678, then DIV x/0:
  - busy 10 cycles.
  - hi=0x1234, lo=0x5678 unchanged afterwards.
  - MFHI/MFLO result matches 0x1234/0x5678.
- Start DIVU, assert reset in 4th busy cycle:
  - Next cycle busy=0, hi=lo=0.
  - hi/lo remain 0 through 10 further cycles.
- During a MULT's busy window, present MULTU and MTLO with valid=1:
  - Both ignored; final hi/lo equal the first MULT's result.
  - A MULT presented in the first non-busy cycle starts and raises busy next cycle.
- valid=0 with MDUOp=MD_MULT and with MD_MTHI: busy stays 0 and hi/lo unchanged.
